// File: rtl/bus_grant_holder.sv
// bus_grant_holder: burst-atomic bus lock behind a fixed-priority arbiter.
// Optional idle-owner watchdog enabled by defining BUS_GRANT_HOLDER_TIMEOUT_EN.
module bus_grant_holder #(
    parameter int width      = 2,
    parameter int data_width = 8,
    parameter int timeout    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [width-1:0]            i_request,
    input  logic [width*data_width-1:0] i_data,
    input  logic [width-1:0]            i_last,
    output logic [width-1:0]            o_arb_request,
    input  logic [width-1:0]            i_arb_grant,
    output logic [width-1:0]            o_ack,
    output logic [width-1:0]            o_owner,
    output logic                        o_valid,
    output logic [data_width-1:0]       o_data,
    output logic                        o_last,
    input  logic                        i_ready,
    output logic                        o_timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           r_state;
    state_t           next_state;
    logic [width-1:0] r_owner;
    logic [width-1:0] next_owner;

    logic [width-1:0]      arb_hit;
    logic [width-1:0]      arb_pick;
    logic                  owner_req;
    logic                  owner_last;
    logic                  beat;
    logic                  timeout_hit;
    logic [data_width-1:0] owner_data;

    assign arb_hit    = i_arb_grant & i_request;
    assign arb_pick   = arb_hit & (~arb_hit + 1'b1);
    assign owner_req  = |(i_request & r_owner);
    assign owner_last = |(i_last & r_owner);
    assign beat       = (r_state == BUSY) & owner_req & i_ready & ~rst;
    assign o_owner    = r_owner;
    assign o_data     = owner_data;

    // One-hot owner selects its data slice; zero owner yields zero data.
    always_comb begin
        owner_data = '0;
        for (int k = 0; k < width; k++) begin
            if (r_owner[k]) begin
                owner_data = owner_data | i_data[k*data_width +: data_width];
            end
        end
    end

`ifdef BUS_GRANT_HOLDER_TIMEOUT_EN
    logic [7:0] r_idle_cnt;

    // Fires on the idle cycle that brings the silent count up to timeout.
    assign timeout_hit = (r_state == BUSY) & ~owner_req & ~rst
                       & ((int'(r_idle_cnt) + 1) >= timeout);

    // Counts BUSY cycles with no beat offered; saturates at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != BUSY || beat) begin
            r_idle_cnt <= '0;
        end else if (!owner_req && r_idle_cnt != 8'hFF) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end
`else
    localparam int unused_timeout = timeout;
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic and combinational outputs of the ownership FSM.
    always_comb begin
        next_state    = r_state;
        next_owner    = r_owner;
        o_arb_request = '0;
        o_valid       = 1'b0;
        o_ack         = '0;
        o_last        = 1'b0;
        o_timeout     = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_arb_request = i_request;
                if (|arb_hit) begin
                    next_state = BUSY;
                    next_owner = arb_pick;
                end
            end
            BUSY: begin
                o_valid = owner_req;
                o_last  = owner_last & owner_req;
                if (beat) begin
                    o_ack = r_owner;
                    if (owner_last) begin
                        next_state = IDLE;
                        next_owner = '0;
                    end
                end else if (timeout_hit) begin
                    o_timeout  = 1'b1;
                    next_state = IDLE;
                    next_owner = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_owner = '0;
            end
        endcase
        if (rst) begin
            o_arb_request = i_request;
            o_valid       = 1'b0;
            o_ack         = '0;
            o_last        = 1'b0;
            o_timeout     = 1'b0;
        end
    end

    // State and owner registers; reset aborts any burst on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
        end else begin
            r_state <= next_state;
            r_owner <= next_owner;
        end
    end

endmodule

// File: tb/tb_bus_grant_holder.sv
// tb_bus_grant_holder: directed scenarios plus random traffic against
// a cycle-level ownership model of bus_grant_holder.
module tb_bus_grant_holder;

    localparam int W  = 4;
    localparam int DW = 8;
`ifdef BUS_GRANT_HOLDER_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif
    localparam int GAP = (TMO > 5) ? 5 : TMO - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  i_request;
    logic [W*DW-1:0] i_data;
    logic [W-1:0]  i_last;
    logic [W-1:0]  o_arb_request;
    logic [W-1:0]  i_arb_grant;
    logic [W-1:0]  o_ack;
    logic [W-1:0]  o_owner;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          i_ready;
    logic          o_timeout;

    int checks   = 0;
    int failures = 0;

    int m_owner  = -1;
    int m_silent = 0;

    always #5 clk = ~clk;

    bus_grant_holder #(
        .width(W),
        .data_width(DW),
        .timeout(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_request(i_request),
        .i_data(i_data),
        .i_last(i_last),
        .o_arb_request(o_arb_request),
        .i_arb_grant(i_arb_grant),
        .o_ack(o_ack),
        .o_owner(o_owner),
        .o_valid(o_valid),
        .o_data(o_data),
        .o_last(o_last),
        .i_ready(i_ready),
        .o_timeout(o_timeout)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] prio(input logic [W-1:0] r);
        logic [W-1:0] g;
        g = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (r[i]) g = '0;
            if (r[i]) g[i] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [W-1:0] onehot(input int idx);
        logic [W-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    // Called at a negedge with inputs applied; checks, then advances one cycle.
    task automatic step();
        logic          busy;
        logic          e_valid;
        logic          e_last;
        logic          e_tmo;
        logic [W-1:0]  e_ack;
        logic [W-1:0]  e_arb;
        logic [W-1:0]  g;
        logic [DW-1:0] e_data;
        #1;
        busy    = (m_owner >= 0);
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_tmo   = 1'b0;
        e_ack   = '0;
        e_data  = '0;
        if (!rst && busy) begin
            e_valid = i_request[m_owner];
            e_last  = i_last[m_owner] && e_valid;
            e_data  = i_data[m_owner*DW +: DW];
            if (e_valid && i_ready) e_ack = onehot(m_owner);
`ifdef BUS_GRANT_HOLDER_TIMEOUT_EN
            e_tmo = !e_valid && (m_silent + 1 >= TMO);
`endif
        end
        e_arb = (rst || !busy) ? i_request : '0;
        check("owner", 32'(o_owner), 32'(onehot(m_owner)));
        check("arb_req", 32'(o_arb_request), 32'(e_arb));
        check("valid", 32'(o_valid), 32'(e_valid));
        check("ack", 32'(o_ack), 32'(e_ack));
        check("last", 32'(o_last), 32'(e_last));
        check("timeout", 32'(o_timeout), 32'(e_tmo));
        if (e_valid) check("data", 32'(o_data), 32'(e_data));
        @(posedge clk);
        if (rst) begin
            m_owner  = -1;
            m_silent = 0;
        end else if (!busy) begin
            g = i_arb_grant & i_request;
            for (int i = W - 1; i >= 0; i--) begin
                if (g[i]) m_owner = i;
            end
            m_silent = 0;
        end else if (e_valid && i_ready) begin
            m_silent = 0;
            if (e_last) m_owner = -1;
        end else if (e_tmo) begin
            m_owner  = -1;
            m_silent = 0;
        end else if (!e_valid && m_silent < 255) begin
            m_silent++;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] req,
                         input int m,
                         input logic [DW-1:0] d,
                         input logic lst,
                         input logic rdy);
        i_request = req;
        i_data    = '0;
        i_last    = '0;
        i_data[m*DW +: DW] = d;
        i_last[m] = lst;
        i_ready   = rdy;
        i_arb_grant = prio(req);
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b1111, 0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);

        // Reset holds with all masters requesting.
        step();
        step();
        check("rst_owner", 32'(o_owner), 32'h0);
        check("rst_arb", 32'(o_arb_request), 32'hF);
        rst = 1'b0;

        // Single master, three-beat burst.
        drive(4'b0100, 2, 8'h00, 1'b0, 1'b1);
        step();
        for (int b = 0; b < 3; b++) begin
            drive(4'b0100, 2, 8'hA0 + 8'(b), b == 2, 1'b1);
            #1;
            check("sm_owner", 32'(o_owner), 32'h4);
            check("sm_data", 32'(o_data), 32'hA0 + 32'(b));
            check("sm_ack", 32'(o_ack), 32'h4);
            step();
        end
        drive(4'b0000, 0, 8'h00, 1'b0, 1'b1);
        check("sm_idle", 32'(o_owner), 32'h0);
        step();

        // Master 3 holds the bus while master 0 requests.
        drive(4'b1000, 3, 8'h00, 1'b0, 1'b1);
        step();
        for (int b = 0; b < 4; b++) begin
            drive(b >= 1 ? 4'b1001 : 4'b1000, 3, 8'hB0 + 8'(b), b == 3, 1'b1);
            #1;
            check("lock_owner", 32'(o_owner), 32'h8);
            check("lock_ack", 32'(o_ack), 32'h8);
            step();
        end
        drive(4'b0001, 0, 8'hC0, 1'b1, 1'b1);
        check("lock_dead", 32'(o_owner), 32'h0);
        step();
        check("lock_next", 32'(o_owner), 32'h1);
        step();

        // Backpressure on owner 1.
        drive(4'b0010, 1, 8'h55, 1'b1, 1'b0);
        step();
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_valid", 32'(o_valid), 32'h1);
            check("bp_data", 32'(o_data), 32'h55);
            check("bp_ack", 32'(o_ack), 32'h0);
            step();
        end
        i_ready = 1'b1;
        #1;
        check("bp_go", 32'(o_ack), 32'h2);
        step();

        // Owner 2 goes quiet mid-burst while master 0 waits.
        drive(4'b0100, 2, 8'h11, 1'b0, 1'b1);
        step();
        step();
        for (int c = 0; c < GAP; c++) begin
            drive(4'b0001, 0, 8'h22, 1'b0, 1'b1);
            #1;
            check("gap_valid", 32'(o_valid), 32'h0);
            check("gap_owner", 32'(o_owner), 32'h4);
            check("gap_arb", 32'(o_arb_request), 32'h0);
            step();
        end
        drive(4'b0100, 2, 8'h33, 1'b1, 1'b1);
        step();

`ifdef BUS_GRANT_HOLDER_TIMEOUT_EN
        // Silent owner is evicted; pending master 3 takes over.
        drive(4'b0010, 1, 8'h00, 1'b0, 1'b1);
        step();
        for (int c = 1; c <= 4; c++) begin
            drive(4'b1000, 3, 8'h44, 1'b0, 1'b1);
            #1;
            check("tmo_pulse", 32'(o_timeout), 32'(c == 4));
            check("tmo_ack", 32'(o_ack), 32'h0);
            step();
        end
        check("tmo_idle", 32'(o_owner), 32'h0);
        check("tmo_arb", 32'(o_arb_request), 32'h8);
        step();
        check("tmo_new", 32'(o_owner), 32'h8);
        drive(4'b1000, 3, 8'h45, 1'b1, 1'b1);
        step();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            i_request = W'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) begin
                i_request[m_owner] = 1'b1;
            end
            i_data  = $urandom;
            i_last  = W'($urandom & $urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                i_arb_grant = onehot(int'($urandom_range(0, W)) - 1);
            end else begin
                i_arb_grant = prio(i_request);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
